// File: rtl/csi2_packet_tx_if.sv
// Request, payload and lane-side signals of the 2-lane CSI-2 packet transmitter.
// master = packet/payload source side, slave = the transmitter itself.
interface csi2_packet_tx_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;
  logic [15:0] pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic [15:0] hs_data;
  logic        hs_en;
  logic        lp_p;
  logic        lp_n;
  logic        busy;
  logic        err_odd_wc;
  logic        err_underrun;
  logic [3:0]  fsm_state;

  modport master (
    output pkt_valid, pkt_vc, pkt_dt, pkt_wc, pay_data, pay_valid,
    input  pkt_ready, pay_ready, hs_data, hs_en, lp_p, lp_n, busy,
           err_odd_wc, err_underrun, fsm_state
  );

  modport slave (
    input  pkt_valid, pkt_vc, pkt_dt, pkt_wc, pay_data, pay_valid,
    output pkt_ready, pay_ready, hs_data, hs_en, lp_p, lp_n, busy,
           err_odd_wc, err_underrun, fsm_state
  );
endinterface

// File: rtl/csi2_packet_tx.sv
// 2-lane MIPI CSI-2 transmit packet engine: LP SoT, sync, header+ECC, payload, CRC, trail.
// Build option: define CSI2_TX_CRC_EN to compute the payload CRC16; otherwise the CRC field is 0x0000.
module csi2_packet_tx #(
  parameter int TLPX      = 2,
  parameter int THS_ZERO  = 4,
  parameter int THS_TRAIL = 3
) (
  input logic             sys_clk,
  input logic             reset,
  csi2_packet_tx_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, LP01, LP00, HSZERO, SYNC, HDR0, HDR1, PAY, CRC, TRAIL
  } state_t;

  state_t      state;
  logic [14:0] cnt;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic [15:0] hs_q;
  logic        hs_en_q;
  logic        lp_p_q;
  logic        lp_n_q;
  logic        pkt_ready_q;
  logic        pay_ready_q;
  logic        busy_q;
  logic        odd_q;
  logic        under_q;
  logic        is_long;
  logic [15:0] pay_word;
  logic [15:0] crc_val;

  // Handshakes: a request moves on a rising edge with pkt_valid && pkt_ready both high.
  // A payload word moves on every rising edge where pay_ready is high; pay_ready leads
  // the PAY slot by one cycle, so the word taken on that edge is on hs_data for the next
  // cycle. pay_valid low on such an edge sends 0x0000 instead (HS cannot stall).
  assign is_long  = (dt >= 6'h10);
  assign pay_word = bus.pay_valid ? bus.pay_data : 16'h0000;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Each lane trails with the inverse of bit 7 of the last byte it sent.
  function automatic logic [15:0] trail_word(input logic [15:0] w);
    return {{8{~w[15]}}, {8{~w[7]}}};
  endfunction

`ifdef CSI2_TX_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 16; i++) r = (r[0] ^ w[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (reset || state == HDR0) crc <= 16'hFFFF;
    else if (pay_ready_q)       crc <= crc16_word(crc, pay_word);
  end

  assign crc_val = crc;
`else
  assign crc_val = 16'h0000;
`endif

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      vc          <= '0;
      dt          <= '0;
      wc          <= '0;
      hs_q        <= '0;
      hs_en_q     <= 1'b0;
      lp_p_q      <= 1'b1;
      lp_n_q      <= 1'b1;
      pkt_ready_q <= 1'b0;
      pay_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      odd_q       <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      odd_q <= 1'b0;
      if (pay_ready_q && !bus.pay_valid) under_q <= 1'b1;
      case (state)
        IDLE: begin
          pkt_ready_q <= 1'b1;
          if (bus.pkt_valid && pkt_ready_q) begin
            if (bus.pkt_dt >= 6'h10 && bus.pkt_wc[0]) begin
              odd_q <= 1'b1;
            end else begin
              vc          <= bus.pkt_vc;
              dt          <= bus.pkt_dt;
              wc          <= bus.pkt_wc;
              pkt_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              lp_p_q      <= 1'b0;
              cnt         <= 15'(TLPX - 1);
              state       <= LP01;
            end
          end
        end
        LP01: if (cnt == '0) begin
          lp_n_q <= 1'b0;
          cnt    <= 15'(TLPX - 1);
          state  <= LP00;
        end else cnt <= cnt - 15'd1;
        LP00: if (cnt == '0) begin
          hs_en_q <= 1'b1;
          hs_q    <= 16'h0000;
          cnt     <= 15'(THS_ZERO - 1);
          state   <= HSZERO;
        end else cnt <= cnt - 15'd1;
        HSZERO: if (cnt == '0) begin
          hs_q  <= 16'hB8B8;
          state <= SYNC;
        end else cnt <= cnt - 15'd1;
        SYNC: begin
          hs_q  <= {wc[7:0], vc, dt};
          state <= HDR0;
        end
        HDR0: begin
          hs_q        <= {2'b00, ecc6({wc, vc, dt}), wc[15:8]};
          cnt         <= wc[15:1] - 15'd1;
          pay_ready_q <= is_long && (wc != 16'h0000);
          state       <= HDR1;
        end
        HDR1: if (!is_long) begin
          hs_q  <= trail_word(hs_q);
          cnt   <= 15'(THS_TRAIL - 1);
          state <= TRAIL;
        end else if (wc == 16'h0000) begin
          hs_q  <= crc_val;
          state <= CRC;
        end else begin
          hs_q        <= pay_word;
          pay_ready_q <= (cnt != '0);
          state       <= PAY;
        end
        // cnt holds the number of words still to be fetched after the one on the lanes.
        PAY: if (cnt != '0) begin
          hs_q        <= pay_word;
          cnt         <= cnt - 15'd1;
          pay_ready_q <= (cnt != 15'd1);
        end else begin
          hs_q  <= crc_val;
          state <= CRC;
        end
        CRC: begin
          hs_q  <= trail_word(hs_q);
          cnt   <= 15'(THS_TRAIL - 1);
          state <= TRAIL;
        end
        TRAIL: if (cnt == '0) begin
          hs_en_q     <= 1'b0;
          hs_q        <= 16'h0000;
          lp_p_q      <= 1'b1;
          lp_n_q      <= 1'b1;
          busy_q      <= 1'b0;
          pkt_ready_q <= 1'b1;
          state       <= IDLE;
        end else cnt <= cnt - 15'd1;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pkt_ready    = pkt_ready_q;
  assign bus.pay_ready    = pay_ready_q;
  assign bus.hs_data      = hs_q;
  assign bus.hs_en        = hs_en_q;
  assign bus.lp_p         = lp_p_q;
  assign bus.lp_n         = lp_n_q;
  assign bus.busy         = busy_q;
  assign bus.err_odd_wc   = odd_q;
  assign bus.err_underrun = under_q;
  assign bus.fsm_state    = state;
endmodule

// File: tb/tb_csi2_packet_tx.sv
// Bench for csi2_packet_tx: per-cycle comparison against a frame model built from the
// packet rules, plus literal expectations for the directed packets.
module tb_csi2_packet_tx;
  localparam int W = 23;  // {gap, pkt_ready, busy, err_odd_wc, lp_p, lp_n, hs_en, hs_data}
  localparam logic [W-1:0] RESET_E = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
  localparam logic [W-1:0] IDLE_E  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
  localparam logic [W-1:0] DROP_E  = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
  localparam logic [23:0] ECC_MASK [6] = '{24'hF12CB7, 24'h F2555B, 24'h749A6D,
                                           24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
  localparam logic [15:0] T1 [10] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB8B8,
                                      16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csi2_packet_tx_if dut_if ();
  csi2_packet_tx dut (.sys_clk(clk), .reset(reset), .bus(dut_if));

  // ---------------- shared state ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  cap_q[$];
  logic [15:0]  plan_words[$];
  bit           plan_gap[$];
  int           plan_id = 0;
  int           cap_base = 0;
  int           odd_seen = 0;
  logic         uf_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [5:0] ecc_model(input logic [23:0] d);
    logic [5:0] e;
    for (int i = 0; i < 6; i++) e[i] = ^(d & ECC_MASK[i]);
    return e;
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    repeat (8) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  function automatic logic [W-1:0] fr(input logic lpp, input logic lpn, input logic en,
                                      input logic [15:0] d, input logic gap);
    return {gap, 1'b0, 1'b1, 1'b0, lpp, lpn, en, d};
  endfunction

  task automatic push_frame(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [15:0] last, crc, w, hdr1;
    int k;
    repeat (2) exp_q.push_back(fr(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0));
    repeat (2) exp_q.push_back(fr(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0));
    repeat (4) exp_q.push_back(fr(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0));
    exp_q.push_back(fr(1'b0, 1'b0, 1'b1, 16'hB8B8, 1'b0));
    exp_q.push_back(fr(1'b0, 1'b0, 1'b1, {wc[7:0], vc, dt}, 1'b0));
    hdr1 = {2'b00, ecc_model({wc, vc, dt}), wc[15:8]};
    exp_q.push_back(fr(1'b0, 1'b0, 1'b1, hdr1, 1'b0));
    last = hdr1;
    if (dt >= 6'h10) begin
      crc = 16'hFFFF;
      k = 0;
      for (int i = 0; i < int'(wc) / 2; i++) begin
        w = plan_gap[i] ? 16'h0000 : plan_words[k];
        if (!plan_gap[i]) k++;
        crc = crc_byte(crc_byte(crc, w[7:0]), w[15:8]);
        exp_q.push_back(fr(1'b0, 1'b0, 1'b1, w, plan_gap[i]));
      end
`ifndef CSI2_TX_CRC_EN
      crc = 16'h0000;
`endif
      exp_q.push_back(fr(1'b0, 1'b0, 1'b1, crc, 1'b0));
      last = crc;
    end
    repeat (3) exp_q.push_back(fr(1'b0, 1'b0, 1'b1, {{8{~last[15]}}, {8{~last[7]}}}, 1'b0));
  endtask

  // ---------------- compare process ----------------
  initial begin : compare_proc
    logic r;
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      r = reset;
      #1;
      if (r) begin
        e = RESET_E;
        exp_q.delete();
        uf_model = 1'b0;
      end else if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = IDLE_E;
      if (e[22]) uf_model = 1'b1;
      check("cycle", {dut_if.pkt_ready, dut_if.busy, dut_if.err_odd_wc, dut_if.lp_p,
                      dut_if.lp_n, dut_if.hs_en, dut_if.hs_data}, 32'(e[21:0]));
      check("err_underrun", 32'(dut_if.err_underrun), 32'(uf_model));
      if (dut_if.hs_en) cap_q.push_back(dut_if.hs_data);
      if (dut_if.err_odd_wc) odd_seen++;
    end
  end

  // ---------------- payload driver ----------------
  initial begin : pay_driver
    int slot, widx, seen;
    slot = 0;
    widx = 0;
    seen = 0;
    dut_if.pay_valid = 1'b0;
    dut_if.pay_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (seen != plan_id) begin
        seen = plan_id;
        slot = 0;
        widx = 0;
      end
      if (dut_if.pay_ready && slot < plan_gap.size()) begin
        dut_if.pay_valid = !plan_gap[slot];
        dut_if.pay_data  = plan_gap[slot] ? 16'($urandom) : plan_words[widx];
        if (!plan_gap[slot]) widx++;
        slot++;
      end else begin
        dut_if.pay_valid = 1'($urandom_range(0, 1));
        dut_if.pay_data  = 16'($urandom);
      end
    end
  end

  // ---------------- request driver ----------------
  function automatic logic [15:0] cap(input int i);
    return cap_q[cap_base + i];
  endfunction

  task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                             input int gap_at, input int gap_len, input bit hold,
                             input int abort_at);
    int n, waited;
    bit drop;
    drop = (dt >= 6'h10) && wc[0];
    n = (dt >= 6'h10 && !drop) ? int'(wc) / 2 : 0;
    plan_words.delete();
    plan_gap.delete();
    for (int i = 0; i < n; i++) begin
      plan_words.push_back(16'($urandom));
      plan_gap.push_back((i >= gap_at) && (i < gap_at + gap_len));
    end
    plan_id++;
    cap_base = cap_q.size();
    dut_if.pkt_vc    = vc;
    dut_if.pkt_dt    = dt;
    dut_if.pkt_wc    = wc;
    dut_if.pkt_valid = 1'b1;
    waited = 0;
    while (!dut_if.pkt_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", 32'(dut_if.pkt_ready), 32'd1);
    if (!dut_if.pkt_ready) begin
      dut_if.pkt_valid = 1'b0;
      return;
    end
    if (drop) exp_q.push_back(DROP_E);
    else push_frame(vc, dt, wc);
    @(negedge clk);
    if (hold) begin
      dut_if.pkt_vc = 2'($urandom);
      dut_if.pkt_dt = 6'($urandom);
      dut_if.pkt_wc = 16'($urandom);
    end else dut_if.pkt_valid = 1'b0;
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      reset = 1'b1;
      dut_if.pkt_valid = 1'b0;
      @(negedge clk);
      check("abort_hs_en", 32'(dut_if.hs_en), 32'd0);
      check("abort_lp", {dut_if.lp_p, dut_if.lp_n}, 32'd3);
      check("abort_busy", 32'(dut_if.busy), 32'd0);
      check("abort_underrun", 32'(dut_if.err_underrun), 32'd0);
      reset = 1'b0;
      plan_words.delete();
      plan_gap.delete();
      plan_id++;
      return;
    end
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("frame_timeout", 32'(exp_q.size()), 32'd0);
    dut_if.pkt_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_proc
    int o0, wc_r;
    logic [5:0] dt_r;
    reset = 1'b1;
    dut_if.pkt_valid = 1'b0;
    dut_if.pkt_vc = 2'd0;
    dut_if.pkt_dt = 6'd0;
    dut_if.pkt_wc = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_lp", {dut_if.lp_p, dut_if.lp_n}, 32'd3);
    check("rst_hs", {dut_if.hs_en, dut_if.hs_data}, 32'd0);
    check("rst_ready", {dut_if.pkt_ready, dut_if.pay_ready, dut_if.busy}, 32'd0);
    check("rst_err", {dut_if.err_odd_wc, dut_if.err_underrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // short frame start
    send_packet(2'd0, 6'h00, 16'h0000, -1, 0, 1'b0, -1);
    check("t1_len", cap_q.size() - cap_base, 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("t1_word%0d", i), cap(i), T1[i]);

    // long line of 320 words
    send_packet(2'd0, 6'h2A, 16'h0280, -1, 0, 1'b0, -1);
    check("t2_len", cap_q.size() - cap_base, 32'd331);
    check("t2_hdr0", cap(5), 32'h802A);
    check("t2_hdr1", cap(6), 32'h0E02);

    // empty long packet
    send_packet(2'd0, 6'h2A, 16'h0000, -1, 0, 1'b0, -1);
    check("t3_len", cap_q.size() - cap_base, 32'd11);
    check("t3_hdr1", cap(6), 32'h1000);
`ifdef CSI2_TX_CRC_EN
    check("t3_crc", cap(7), 32'hFFFF);
    check("t3_trail", cap(8), 32'h0000);
`else
    check("t3_crc", cap(7), 32'h0000);
    check("t3_trail", cap(8), 32'hFFFF);
`endif

    // odd word count is dropped
    o0 = odd_seen;
    send_packet(2'd0, 6'h2A, 16'h0003, -1, 0, 1'b0, -1);
    @(negedge clk);
    check("t5_pulses", odd_seen - o0, 32'd1);
    check("t5_idle", {dut_if.busy, dut_if.lp_p, dut_if.lp_n}, 32'd3);

    // randomized packets, some back-to-back with pkt_valid held
    for (int t = 0; t < 14; t++) begin
      dt_r = 6'($urandom);
      wc_r = (dt_r >= 6'h10) ? $urandom_range(0, 48) : int'($urandom_range(0, 65535));
      send_packet(2'($urandom), dt_r, 16'(wc_r), -1, 0, 1'($urandom_range(0, 1)), -1);
    end

    // payload gap mid-line
    send_packet(2'd1, 6'h2B, 16'd40, 8, 3, 1'b0, -1);
    check("t4_len", cap_q.size() - cap_base, 32'd31);
    check("t4_gap", {cap(15), cap(16)}, 32'd0);
    check("t4_gap_last", cap(17), 32'd0);
    check("t4_underrun", 32'(dut_if.err_underrun), 32'd1);

    // random packets with random gaps
    for (int t = 0; t < 6; t++) begin
      wc_r = 2 * $urandom_range(1, 20);
      send_packet(2'($urandom), 6'h2A, 16'(wc_r), $urandom_range(0, wc_r / 2 - 1),
                  $urandom_range(0, 3), 1'b0, -1);
    end

    // reset in the middle of PAY, then a normal packet
    send_packet(2'd2, 6'h2A, 16'd64, -1, 0, 1'b0, 20);
    @(negedge clk);
    send_packet(2'd3, 6'h2C, 16'd10, -1, 0, 1'b0, -1);
    check("t6_len", cap_q.size() - cap_base, 32'd16);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
